// File: rtl/simon_input_checker.sv
// simon_input_checker
//   Checks the player's button presses against the packed color sequence that
//   the playback stage just showed. It checks one press per color, in order,
//   and reports the result of the round to the game controller.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   start      : single-cycle pulse, begins a check round (ignored while busy)
//   colors     : packed sequence, color i = colors[2i+1:2i], i=0 played first
//   round_len  : number of colors to check (0 -> 1, above NUM_COLORS -> NUM_COLORS)
//   btn_valid  : single-cycle pulse per debounced press
//   btn_color  : color of the press, valid with btn_valid
//   busy       : high while a round is being checked
//   expect_idx : index of the next expected color
//   pass       : single-cycle pulse, every press of the round was correct
//   fail       : single-cycle pulse, wrong color or inter-press timeout
//   fail_code  : 0 none, 1 wrong color, 2 timeout; held until the next start
module simon_input_checker #(
  parameter int unsigned NUM_COLORS     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 300000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [2*NUM_COLORS-1:0]       colors,
  input  logic [$clog2(NUM_COLORS):0]   round_len,
  input  logic                          btn_valid,
  input  logic [1:0]                    btn_color,
  output logic                          busy,
  output logic [$clog2(NUM_COLORS)-1:0] expect_idx,
  output logic                          pass,
  output logic                          fail,
  output logic [1:0]                    fail_code
);

  localparam int unsigned IW = $clog2(NUM_COLORS);
  localparam int unsigned LW = IW + 1;
  localparam int unsigned CW = 2 * NUM_COLORS;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_WRONG   = 2'd1;
  localparam logic [1:0] FC_TIMEOUT = 2'd2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   colors_q;
  logic [LW-1:0]   len_q;
  logic [IW-1:0]   expect_idx_q;
  logic [TW-1:0]   timer_q;
  logic            busy_q;
  logic            pass_q;
  logic            fail_q;
  logic [1:0]      fail_code_q;

  logic [LW-1:0]   len_clamp_c;
  logic [1:0]      exp_color_c;
  logic            last_c;
  logic            timeout_c;

  // Round length clamp: zero still checks one color, oversize checks all.
  always_comb begin
    len_clamp_c = round_len;
    if (round_len == '0) begin
      len_clamp_c = LW'(1);
    end else if (round_len > LW'(NUM_COLORS)) begin
      len_clamp_c = LW'(NUM_COLORS);
    end
  end

  // Expected color comes from the snapshot, never from the live input.
  assign exp_color_c = colors_q[{expect_idx_q, 1'b0} +: 2];
  assign last_c      = ((LW'(expect_idx_q) + LW'(1)) == len_q);
  assign timeout_c   = (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // Round FSM with registered outputs; pass/fail default low so they pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      colors_q     <= '0;
      len_q        <= '0;
      expect_idx_q <= '0;
      timer_q      <= '0;
      busy_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_code_q  <= FC_NONE;
    end else begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            colors_q     <= colors;
            len_q        <= len_clamp_c;
            expect_idx_q <= '0;
            timer_q      <= '0;
            fail_code_q  <= FC_NONE;
            busy_q       <= 1'b1;
            state_q      <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A press on the terminal-count cycle wins over the timeout.
          if (btn_valid) begin
            if (btn_color == exp_color_c) begin
              if (last_c) begin
                pass_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                expect_idx_q <= expect_idx_q + IW'(1);
                timer_q      <= '0;
              end
            end else begin
              fail_q      <= 1'b1;
              fail_code_q <= FC_WRONG;
              busy_q      <= 1'b0;
              state_q     <= S_IDLE;
            end
          end else if (timeout_c) begin
            fail_q      <= 1'b1;
            fail_code_q <= FC_TIMEOUT;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign expect_idx = expect_idx_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign fail_code  = fail_code_q;

endmodule

// File: doc/simon_input_checker.md
Name: simon_input_checker

Overview:
- Downstream stage of the color-sequence playback block in the Simon Says game.
- Once the playback has shown round_len colors, this block checks the player's button presses against the same 32-bit packed color sequence, one press per color, in order.
- Reports round pass or fail to the game controller. Fail is either a wrong color or an inter-press timeout.
- Sits between the debounced button front end and the top-level game FSM.

Parameters:
- NUM_COLORS, 16, number of 2-bit colors packed in the sequence word; fixes the colors width at 2*NUM_COLORS.
- TIMEOUT_CYCLES, 300000000, clk cycles allowed between start and first press, and between consecutive presses (3 s at 100 MHz).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a check round.
- colors  input  32  packed sequence; color i = colors[2i+1:2i], i=0 is played first.
- round_len  input  5  number of colors to check this round; valid 1..16.
- btn_valid  input  1  single-cycle pulse from the debouncer, one per press.
- btn_color  input  2  color of the press; valid when btn_valid=1.
- busy  output  1  high while a round is being checked.
- expect_idx  output  4  index of the next color expected.
- pass  output  1  single-cycle pulse; all round_len presses were correct.
- fail  output  1  single-cycle pulse; round failed.
- fail_code  output  2  0 none, 1 wrong color, 2 timeout; holds until the next start.

Behaviour:
- Reset: asynchronous, active-high; clock is clk.
  - Reset state: state=IDLE, busy=0, expect_idx=0, pass=0, fail=0, fail_code=0, timeout counter=0, snapshot registers=0.
  - Reset asserted mid-round aborts the round immediately, with no pass or fail pulse.
- Outputs: all outputs are registered.
- FSM has two states, IDLE and WAIT.
- IDLE:
  - start=1 captures colors into the snapshot register and latches len_q = clamp(round_len).
  - Clamp rule: 0 -> 1; values above 16 are impossible at 5 bits except 17..31 -> 16.
  - Same edge: expect_idx=0, timer=0, fail_code=0, busy=1, next state WAIT.
  - btn_valid is ignored in IDLE.
- WAIT:
  - start is ignored while busy.
  - btn_valid=1 compares btn_color with snapshot color[expect_idx].
  - Match and expect_idx == len_q-1: next cycle pass=1, busy=0, state IDLE.
  - Match otherwise: expect_idx increments and timer clears to 0.
  - Mismatch: next cycle fail=1, fail_code=1, busy=0, state IDLE.
  - No press: timer increments by 1 each cycle. When timer reaches TIMEOUT_CYCLES-1 and no btn_valid is present, next cycle fail=1, fail_code=2, busy=0, state IDLE.
  - btn_valid in the same cycle as the timeout terminal count: the press is evaluated; timeout does not fire.
- Latency: the decision cycle is the cycle holding btn_valid or the terminal count. pass/fail rise on the edge that ends the decision cycle and last exactly 1 cycle. busy falls on that same edge.
- start in the same cycle as the pass/fail pulse is accepted, since the state is already IDLE.
- Snapshot: later changes on colors or round_len have no effect on the round in progress.
- Widths:
  - expect_idx is 4 bits and never wraps within a round; the maximum used value is 15.
  - The timer is wide enough for TIMEOUT_CYCLES-1 and saturates by construction, because the FSM leaves WAIT at the terminal count.
- pass and fail are never high in the same cycle.

Test Plan:
- Full correct round: TIMEOUT_CYCLES=50, colors=32'hE4E4E4E4, round_len=16, start, then presses 0,1,2,3 repeated, 10 cycles apart -> expect_idx steps 0..15; pass=1 for one cycle after the 16th press; busy=0; fail_code=0.
- Wrong color: colors=32'h0000001B, round_len=3, presses 3 then 1 -> fail=1 one cycle after the 2nd press; fail_code=1; expect_idx=1; no pass.
- Timeout: TIMEOUT_CYCLES=20, start, no presses -> fail=1 exactly 21 cycles after start is sampled; fail_code=2. Repeat with a correct press at cycle 15 -> timeout restarts, no fail before cycle 15+21.
- Press on the terminal-count cycle: drive a correct btn_valid in the same cycle the timer reaches 19 -> no timeout; index advances.
- Ignored inputs and clamp: btn_valid in IDLE -> no output change. start while busy -> no restart. round_len=0 -> a single correct press gives pass. colors changed mid-round -> checks still use the snapshot.
- Async reset mid-round: assert reset between presses 5 and 6 -> all outputs 0 immediately, with no clock edge needed; a new start after release runs a normal round from expect_idx=0.
